// File: rtl/bcd_to_binary.sv
// Packed-BCD to binary converter (reverse double dabble), one result bit per cycle.
// Optional invalid-digit rejection is enabled by defining BCD_CHECK_EN.
module bcd_to_binary #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd,
    output logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  ready,
    output logic                  err
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_CONVERT = 1'b1;

    logic [0:0]       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [SR_W-1:0]  sr_reg;
    logic [SR_W-1:0]  shifted;
    logic [SR_W-1:0]  sr_next;
    logic [BCD_W-1:0] digits_corr;
    logic [BIN_W-1:0] bin_reg;
    logic             busy_reg;
    logic             ready_reg;
    logic             last_step;

    assign shifted = sr_reg >> 1;

    // Digits stay in the upper field; any digit that picked up a half-weight bit (>= 8) loses 3.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_corr
            logic [3:0] digit_sh;
            assign digit_sh = shifted[BIN_W + 4*gi +: 4];
            assign digits_corr[4*gi +: 4] = (digit_sh >= 4'd8) ? (digit_sh - 4'd3) : digit_sh;
        end
    endgenerate

    assign sr_next   = {digits_corr, shifted[BIN_W-1:0]};
    assign last_step = (cnt_reg == CNT_W'(BIN_W - 1));

`ifdef BCD_CHECK_EN
    logic [DIGITS-1:0] digit_bad;
    logic              err_reg;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_check
            assign digit_bad[gi] = (bcd[4*gi +: 4] > 4'd9);
        end
    endgenerate

    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            sr_reg    <= '0;
            bin_reg   <= '0;
            busy_reg  <= 1'b0;
            ready_reg <= 1'b0;
`ifdef BCD_CHECK_EN
            err_reg   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
`ifdef BCD_CHECK_EN
                        if (|digit_bad) begin
                            // Reject without converting: immediate error response.
                            err_reg   <= 1'b1;
                            ready_reg <= 1'b1;
                            bin_reg   <= '0;
                        end else begin
                            err_reg   <= 1'b0;
                            sr_reg    <= {bcd, {BIN_W{1'b0}}};
                            cnt_reg   <= '0;
                            busy_reg  <= 1'b1;
                            ready_reg <= 1'b0;
                            state_reg <= ST_CONVERT;
                        end
`else
                        sr_reg    <= {bcd, {BIN_W{1'b0}}};
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                        ready_reg <= 1'b0;
                        state_reg <= ST_CONVERT;
`endif
                    end
                end
                default: begin
                    sr_reg  <= sr_next;
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    if (last_step) begin
                        bin_reg   <= sr_next[BIN_W-1:0];
                        busy_reg  <= 1'b0;
                        ready_reg <= 1'b1;
                        cnt_reg   <= '0;
                        state_reg <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign bin   = bin_reg;
    assign busy  = busy_reg;
    assign ready = ready_reg;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Self-checking bench for bcd_to_binary: vector table, hand-written corner sequences,
// and randomized values checked against an arithmetic decimal model.
module tb_bcd_to_binary;

    localparam int DIGITS = 4;
    localparam int BIN_W  = 14;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [15:0]       bcd;
    logic [BIN_W-1:0]  bin;
    logic              busy;
    logic              ready;
    logic              err;

    int checks = 0;
    int errors = 0;

    bcd_to_binary #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bcd   (bcd),
        .bin   (bin),
        .busy  (busy),
        .ready (ready),
        .err   (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]      bcd;
        logic [BIN_W-1:0] exp;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Decimal model: digit i of n is (n / 10^i) % 10.
    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'((n / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    // Full conversion issued from the current cycle; returns right after the completion edge,
    // so a following call starts on the very next edge (maximum issue rate).
    task automatic convert(input logic [15:0] b, input logic [BIN_W-1:0] exp, input string name);
        start = 1'b1;
        bcd   = b;
        tick();
        start = 1'b0;
        bcd   = 16'($urandom);
        chk({name, "_busy0"}, {31'b0, busy}, 32'd1);
        chk({name, "_ready0"}, {31'b0, ready}, 32'd0);
        for (int k = 1; k < BIN_W; k++) begin
            tick();
            chk({name, "_busy"}, {31'b0, busy}, 32'd1);
        end
        tick();
        chk({name, "_ready"}, {31'b0, ready}, 32'd1);
        chk({name, "_busydone"}, {31'b0, busy}, 32'd0);
        chk({name, "_bin"}, 32'(bin), 32'(exp));
        chk({name, "_err"}, {31'b0, err}, 32'd0);
        $display("conv %s bcd=%h bin=%0d exp=%0d", name, b, bin, exp);
    endtask

    initial begin
        vecs[0]  = '{16'h0000, 14'd0};
        vecs[1]  = '{16'h9999, 14'd9999};
        vecs[2]  = '{16'h1234, 14'd1234};
        vecs[3]  = '{16'h0042, 14'd42};
        vecs[4]  = '{16'h0001, 14'd1};
        vecs[5]  = '{16'h0010, 14'd10};
        vecs[6]  = '{16'h0099, 14'd99};
        vecs[7]  = '{16'h0100, 14'd100};
        vecs[8]  = '{16'h1000, 14'd1000};
        vecs[9]  = '{16'h8000, 14'd8000};
        vecs[10] = '{16'h5555, 14'd5555};
        vecs[11] = '{16'h9090, 14'd9090};

        rst   = 1'b1;
        start = 1'b0;
        bcd   = '0;
        tick();
        tick();
        chk("reset_bin", 32'(bin), 32'd0);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_ready", {31'b0, ready}, 32'd0);
        chk("reset_err", {31'b0, err}, 32'd0);

        // Reset coincident with start must win.
        start = 1'b1;
        bcd   = 16'h0777;
        tick();
        chk("rst_start_busy", {31'b0, busy}, 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        tick();
        chk("rst_start_idle", {31'b0, busy}, 32'd0);

        for (int i = 0; i < 12; i++)
            convert(vecs[i].bcd, vecs[i].exp, $sformatf("vec%0d", i));

        // Extra starts at conversion cycle 3 and on the completion edge are ignored.
        start = 1'b1;
        bcd   = 16'h1234;
        tick();
        start = 1'b0;
        repeat (2) tick();
        start = 1'b1;
        bcd   = 16'h9999;
        tick();
        start = 1'b0;
        chk("restart3_busy", {31'b0, busy}, 32'd1);
        repeat (10) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_ready", {31'b0, ready}, 32'd1);
        chk("restart_bin", 32'(bin), 32'd1234);
        chk("restart_busy", {31'b0, busy}, 32'd0);
        tick();
        chk("restart_hold_ready", {31'b0, ready}, 32'd1);
        chk("restart_hold_busy", {31'b0, busy}, 32'd0);
        chk("restart_hold_bin", 32'(bin), 32'd1234);
        $display("seq restart bin=%0d ready=%0d", bin, ready);

        // Reset at conversion cycle 7 aborts.
        start = 1'b1;
        bcd   = 16'h0500;
        tick();
        start = 1'b0;
        repeat (6) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_ready", {31'b0, ready}, 32'd0);
        chk("abort_bin", 32'(bin), 32'd0);
        $display("seq abort busy=%0d ready=%0d bin=%0d", busy, ready, bin);
        convert(16'h0042, 14'd42, "after_abort");

`ifdef BCD_CHECK_EN
        start = 1'b1;
        bcd   = 16'h00A0;
        tick();
        start = 1'b0;
        chk("bad_err", {31'b0, err}, 32'd1);
        chk("bad_ready", {31'b0, ready}, 32'd1);
        chk("bad_bin", 32'(bin), 32'd0);
        chk("bad_busy", {31'b0, busy}, 32'd0);
        tick();
        chk("bad_busy_later", {31'b0, busy}, 32'd0);
        chk("bad_err_hold", {31'b0, err}, 32'd1);
        $display("seq badbcd err=%0d ready=%0d bin=%0d", err, ready, bin);
        convert(16'h0010, 14'd10, "after_bad");
`endif

        // Randomized back-to-back conversions against the decimal model.
        for (int i = 0; i < 200; i++) begin
            int n;
            n = int'($urandom_range(0, 9999));
            convert(to_bcd(n), BIN_W'(n), $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
